// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the memmod command/data bus.
// Used by mem_bus_master, memmod and their benches.
//   - bus widths (address, data, command)
//   - 2-bit opcodes carried in cmd[4:3]; cmd[2:0] carries beats-1
//   - bus-master FSM state encoding
//   - mk_cmd(): packs an opcode and a beat count into a command word
package mem_bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CMD_W  = 5;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WADDR = 2'b01;
    localparam logic [1:0] OP_WDATA = 2'b10;
    localparam logic [1:0] OP_RADDR = 2'b11;

    localparam logic [CMD_W-1:0] CMD_NOP = 5'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WADDR   = 3'd1,
        ST_WDATA   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RADDR   = 3'd4,
        ST_RWAIT   = 3'd5,
        ST_RDATA   = 3'd6
    } state_e;

    function automatic logic [CMD_W-1:0] mk_cmd(input logic [1:0] op,
                                                 input logic [2:0] beats_m1);
        return {op, beats_m1};
    endfunction

endpackage

// File: rtl/mem_bus_master.sv
// mem_bus_master: bus-master stage in front of memmod.
// Converts a valid/ready request and a valid-only response stream into
// cycle-accurate command/data bus transactions.
//
// Parameters
//   READ_LATENCY  cycles from the read-address cycle to the first read beat
//                 driven by memmod (legal 2..7)
//   MAX_BEATS     maximum read burst length (power of 2, at most 8)
//
// Ports
//   clk, rst      single clock, synchronous active-high reset
//   req_valid     request present
//   req_ready     request accepted when valid && ready (high only in IDLE)
//   req_write     1 = single-beat write, 0 = burst read
//   req_addr      start address
//   req_len       read beats minus 1 (ignored for writes)
//   req_wdata     write data
//   rsp_valid     read beat valid (no backpressure)
//   rsp_last      final beat of the burst
//   rsp_rdata     read data
//   cmd           memmod command {opcode, beats-1}
//   data_out      bus drive value
//   data_oe       bus drive enable (the tristate is built one level up)
//   data_in       sampled bus value
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int MAX_BEATS    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_last,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [CMD_W-1:0]  cmd,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in
);

    // Latency counter starts at READ_LATENCY-1 in RADDR, so RWAIT lasts
    // READ_LATENCY-1 cycles and RDATA begins READ_LATENCY cycles after RADDR.
    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);
    localparam logic [2:0] LEN_MASK = 3'(MAX_BEATS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        len_q, len_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [2:0]        beat_cnt_q, beat_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_last_q, rsp_last_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            len_q       <= '0;
            lat_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            len_q       <= len_d;
            lat_cnt_q   <= lat_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        len_d       = len_q;
        lat_cnt_d   = lat_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        req_ready   = 1'b0;
        cmd         = CMD_NOP;
        data_out    = '0;
        data_oe     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    len_d   = req_len & LEN_MASK;
                    state_d = req_write ? ST_WADDR : ST_RADDR;
                end
            end
            ST_WADDR: begin
                cmd      = mk_cmd(OP_WADDR, 3'd0);
                data_out = addr_q;
                data_oe  = 1'b1;
                state_d  = ST_WDATA;
            end
            ST_WDATA: begin
                cmd      = mk_cmd(OP_WDATA, 3'd0);
                data_out = wdata_q;
                data_oe  = 1'b1;
                state_d  = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            ST_RADDR: begin
                cmd        = mk_cmd(OP_RADDR, len_q);
                data_out   = addr_q;
                data_oe    = 1'b1;
                lat_cnt_d  = LAT_LOAD;
                beat_cnt_d = len_q;
                state_d    = ST_RWAIT;
            end
            ST_RWAIT: begin
                // First RWAIT cycle is the bus turnaround; memmod drives
                // from the first RDATA cycle on.
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                // Beat sampled here is presented one cycle later.
                rsp_valid_d = 1'b1;
                rsp_rdata_d = data_in;
                rsp_last_d  = (beat_cnt_q == 3'd0);
                if (beat_cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_cnt_d = beat_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset wins over whatever the current state would drive, so an
        // aborted transaction never leaves the bus driven in the reset cycle.
        if (rst) begin
            req_ready = 1'b0;
            cmd       = CMD_NOP;
            data_out  = '0;
            data_oe   = 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: three instances (READ_LATENCY 2, 4, 7) share
// clock and reset. A transaction-level model schedules, on acceptance, the
// expected bus and response activity into a cycle ring; memmod's read beats
// come from the same schedule. One compare process checks every cycle.
module tb_mem_bus_master;
    import mem_bus_pkg::*;

    localparam int NI   = 3;
    localparam int SL   = 32;
    localparam int LOGN = 2048;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 4 : 7);
    endfunction

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       req_valid [NI];
    logic       req_ready [NI];
    logic       req_write [NI];
    logic [7:0] req_addr  [NI];
    logic [2:0] req_len   [NI];
    logic [7:0] req_wdata [NI];
    logic       rsp_valid [NI];
    logic       rsp_last  [NI];
    logic [7:0] rsp_rdata [NI];
    logic [4:0] cmd       [NI];
    logic [7:0] data_out  [NI];
    logic       data_oe   [NI];

    // expected-activity ring, indexed by cycle % SL
    logic [4:0] e_cmd  [NI][SL];
    logic       e_oe   [NI][SL];
    logic [7:0] e_dout [NI][SL];
    logic       e_rv   [NI][SL];
    logic       e_rl   [NI][SL];
    logic [7:0] e_rd   [NI][SL];
    logic       e_rdy  [NI][SL];
    logic       m_drv  [NI][SL];
    logic [7:0] m_val  [NI][SL];
    logic [7:0] mem    [NI][256];

    // observed DUT outputs per cycle, for the literal checks
    logic [4:0] log_cmd  [NI][LOGN];
    logic [7:0] log_dout [NI][LOGN];
    logic       log_oe   [NI][LOGN];
    logic       log_rv   [NI][LOGN];
    logic       log_rl   [NI][LOGN];
    logic [7:0] log_rd   [NI][LOGN];
    logic       log_rdy  [NI][LOGN];

    int acc_cnt [NI];
    int acc_cyc [NI];
    int s_now, s_prev;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [7:0] din;
        assign din = data_oe[g] ? data_out[g]
                   : (m_drv[g][cyc % SL] ? m_val[g][cyc % SL] : 8'hEE);
        mem_bus_master #(.READ_LATENCY(lat_of(g)), .MAX_BEATS(8)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_len   (req_len[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_last  (rsp_last[g]),
            .rsp_rdata (rsp_rdata[g]),
            .cmd       (cmd[g]),
            .data_out  (data_out[g]),
            .data_oe   (data_oe[g]),
            .data_in   (din)
        );
    end

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic clr_slot(input int k, input int s);
        e_cmd[k][s]  = CMD_NOP;
        e_oe[k][s]   = 1'b0;
        e_dout[k][s] = 8'h00;
        e_rv[k][s]   = 1'b0;
        e_rl[k][s]   = 1'b0;
        e_rd[k][s]   = 8'h00;
        e_rdy[k][s]  = 1'b1;
        m_drv[k][s]  = 1'b0;
        m_val[k][s]  = 8'h00;
    endtask

    // Transaction accepted at the end of cycle c: fill in what must happen.
    task automatic sched(input int k, input int c);
        int t, n, L;
        logic [7:0] a;
        t = c + 1;
        if (req_write[k]) begin
            e_cmd[k][t % SL]        = {OP_WADDR, 3'd0};
            e_oe[k][t % SL]         = 1'b1;
            e_dout[k][t % SL]       = req_addr[k];
            e_rdy[k][t % SL]        = 1'b0;
            e_cmd[k][(t + 1) % SL]  = {OP_WDATA, 3'd0};
            e_oe[k][(t + 1) % SL]   = 1'b1;
            e_dout[k][(t + 1) % SL] = req_wdata[k];
            e_rdy[k][(t + 1) % SL]  = 1'b0;
            e_rdy[k][(t + 2) % SL]  = 1'b0;
            mem[k][req_addr[k]]     = req_wdata[k];
        end else begin
            L = lat_of(k);
            n = int'(req_len[k]) + 1;
            e_cmd[k][t % SL]  = {OP_RADDR, req_len[k]};
            e_oe[k][t % SL]   = 1'b1;
            e_dout[k][t % SL] = req_addr[k];
            for (int j = 0; j < L + n; j++) e_rdy[k][(t + j) % SL] = 1'b0;
            for (int i = 0; i < n; i++) begin
                a = req_addr[k] + 8'(i);
                m_drv[k][(t + L + i) % SL]    = 1'b1;
                m_val[k][(t + L + i) % SL]    = mem[k][a];
                e_rv[k][(t + L + 1 + i) % SL] = 1'b1;
                e_rd[k][(t + L + 1 + i) % SL] = mem[k][a];
                e_rl[k][(t + L + 1 + i) % SL] = (i == n - 1);
            end
        end
    endtask

    always @(negedge clk) begin
        s_now  = cyc % SL;
        s_prev = (cyc + SL - 1) % SL;
        for (int k = 0; k < NI; k++) begin
            clr_slot(k, s_prev);
            if (cyc < LOGN) begin
                log_cmd[k][cyc]  = cmd[k];
                log_dout[k][cyc] = data_out[k];
                log_oe[k][cyc]   = data_oe[k];
                log_rv[k][cyc]   = rsp_valid[k];
                log_rl[k][cyc]   = rsp_last[k];
                log_rd[k][cyc]   = rsp_rdata[k];
                log_rdy[k][cyc]  = req_ready[k];
            end
            if (rst) begin
                chk("rst_cmd", k, int'(cmd[k]), 0);
                chk("rst_oe", k, int'(data_oe[k]), 0);
                chk("rst_dout", k, int'(data_out[k]), 0);
                chk("rst_ready", k, int'(req_ready[k]), 0);
                for (int i = 0; i < SL; i++) clr_slot(k, i);
            end else begin
                chk("cmd", k, int'(cmd[k]), int'(e_cmd[k][s_now]));
                chk("oe", k, int'(data_oe[k]), int'(e_oe[k][s_now]));
                if (e_oe[k][s_now]) chk("dout", k, int'(data_out[k]), int'(e_dout[k][s_now]));
                chk("ready", k, int'(req_ready[k]), int'(e_rdy[k][s_now]));
                chk("rsp_valid", k, int'(rsp_valid[k]), int'(e_rv[k][s_now]));
                if (e_rv[k][s_now]) begin
                    chk("rsp_rdata", k, int'(rsp_rdata[k]), int'(e_rd[k][s_now]));
                    chk("rsp_last", k, int'(rsp_last[k]), int'(e_rl[k][s_now]));
                end
                chk("contention", k, int'(data_oe[k] && m_drv[k][s_now]), 0);
                if (req_valid[k] && e_rdy[k][s_now]) begin
                    sched(k, cyc);
                    acc_cyc[k] = cyc;
                    acc_cnt[k]++;
                end
            end
        end
    end

    // Holds the request until the model accepts it; returns the acceptance
    // cycle. Leaves req_valid high so a following call runs back-to-back.
    task automatic do_req(input int k, input logic wr, input logic [7:0] a,
                          input logic [2:0] l, input logic [7:0] wd, output int acc);
        int n0;
        n0 = acc_cnt[k];
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = a;
        req_len[k]   = l;
        req_wdata[k] = wd;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt[k] != n0) begin
                acc = acc_cyc[k];
                break;
            end
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL req_timeout dut%0d: got no acceptance, required within 40 cycles", k);
            acc = 0;
        end
    endtask

    task automatic idle_req(input int k);
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int a, aw;
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = 8'h00;
            req_len[k]   = 3'd0;
            req_wdata[k] = 8'h00;
            acc_cnt[k]   = 0;
            acc_cyc[k]   = 0;
            for (int i = 0; i < SL; i++) clr_slot(k, i);
            for (int i = 0; i < 256; i++) mem[k][i] = 8'(i) ^ 8'h5A;
        end
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2);

        // single write 0x3C <= 0xA5, then read it back
        do_req(0, 1'b1, 8'h3C, 3'd0, 8'hA5, aw);
        idle_req(0);
        wait_cycles(5);
        chk("wr_waddr_cmd", 0, int'(log_cmd[0][aw + 1]), 'h08);
        chk("wr_waddr_bus", 0, int'(log_dout[0][aw + 1]), 'h3C);
        chk("wr_wdata_cmd", 0, int'(log_cmd[0][aw + 2]), 'h10);
        chk("wr_wdata_bus", 0, int'(log_dout[0][aw + 2]), 'hA5);
        chk("wr_release_oe", 0, int'(log_oe[0][aw + 3]), 0);
        do_req(0, 1'b0, 8'h3C, 3'd0, 8'h00, a);
        idle_req(0);
        wait_cycles(8);
        chk("rb_data", 0, int'(log_rd[0][a + 4]), 'hA5);
        chk("rb_last", 0, int'(log_rl[0][a + 4]), 1);

        // writes 0x10..0x13 <= 0x11..0x14, then burst read, req_valid held high
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1'b1, 8'(8'h10 + i), 3'd0, 8'(8'h11 + i), aw);
        end
        do_req(0, 1'b0, 8'h10, 3'd3, 8'h00, a);
        idle_req(0);
        wait_cycles(12);
        chk("b2b_accept_gap", 0, a - aw, 4);
        chk("burst_cmd", 0, int'(log_cmd[0][a + 1]), 'h1B);
        chk("burst_pre_valid", 0, int'(log_rv[0][a + 3]), 0);
        for (int i = 0; i < 4; i++) begin
            chk("burst_valid", 0, int'(log_rv[0][a + 4 + i]), 1);
            chk("burst_data", 0, int'(log_rd[0][a + 4 + i]), 'h11 + i);
            chk("burst_last", 0, int'(log_rl[0][a + 4 + i]), (i == 3) ? 1 : 0);
        end

        // max burst with address wrap inside memmod
        do_req(0, 1'b0, 8'hFC, 3'd7, 8'h00, a);
        idle_req(0);
        wait_cycles(16);
        chk("max_cmd", 0, int'(log_cmd[0][a + 1]), 'h1F);
        chk("max_first", 0, int'(log_rd[0][a + 4]), 'hA6);
        chk("max_wrap", 0, int'(log_rd[0][a + 8]), 'h5A);
        chk("max_last8", 0, int'(log_rl[0][a + 11]), 1);
        chk("max_last7", 0, int'(log_rl[0][a + 10]), 0);
        chk("max_end", 0, int'(log_rv[0][a + 12]), 0);

        // reset in the middle of RDATA of a 4-beat read
        do_req(0, 1'b0, 8'h10, 3'd3, 8'h00, a);
        idle_req(0);
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(4);
        chk("rstmid_oe", 0, int'(log_oe[0][a + 5]), 0);
        chk("rstmid_cmd", 0, int'(log_cmd[0][a + 5]), 0);
        chk("rstmid_valid", 0, int'(log_rv[0][a + 5]), 0);
        chk("rstmid_ready", 0, int'(log_rdy[0][a + 5]), 1);

        // latency sweep: write 0x40 <= 0x77, then a 2-beat read back-to-back
        for (int k = 1; k < NI; k++) begin
            do_req(k, 1'b1, 8'h40, 3'd0, 8'h77, aw);
            do_req(k, 1'b0, 8'h40, 3'd1, 8'h00, a);
            idle_req(k);
            wait_cycles(14);
            chk("sweep_gap", k, a - aw, 4);
            chk("sweep_pre", k, int'(log_rv[k][a + ((k == 1) ? 5 : 8)]), 0);
            chk("sweep_first", k, int'(log_rv[k][a + ((k == 1) ? 6 : 9)]), 1);
            chk("sweep_data", k, int'(log_rd[k][a + ((k == 1) ? 6 : 9)]), 'h77);
            chk("sweep_beat2", k, int'(log_rd[k][a + ((k == 1) ? 7 : 10)]), 'h1B);
            chk("sweep_last", k, int'(log_rl[k][a + ((k == 1) ? 7 : 10)]), 1);
        end

        wait_cycles(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
